// File: rtl/rmii_eth_tx.sv
// RMII Ethernet transmitter.
// Buffers payload bytes in a FIFO, then on send_in emits a complete Ethernet II
// frame on the RMII TX pins: preamble + SFD, fixed MAC header, payload, zero pad
// to the 46-byte minimum, and CRC-32 FCS, followed by a 96-bit-time gap.
//
// Ports:
//   clk_in    single clock, all logic on its rising edge
//   rst_in    synchronous active-high reset; aborts any frame in flight
//   data_in   payload byte, written when valid_in=1 and busy_out=0
//   valid_in  data_in qualifier
//   send_in   one-cycle pulse starting transmission of the buffered bytes
//   busy_out  high from accepted send_in until the inter-frame gap completes
//   drop_out  one-cycle pulse after an input byte was discarded
//   eth_txen  RMII TX_EN
//   eth_txd   RMII TXD[1:0], 2'b00 whenever eth_txen=0
module rmii_eth_tx #(
  parameter logic [47:0] DEST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE  = 16'h0800,
  parameter int unsigned FIFO_DEPTH = 2048,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       send_in,
  output logic       busy_out,
  output logic       drop_out,
  output logic       eth_txen,
  output logic [1:0] eth_txd
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned DivW  = 16;
  localparam logic [10:0] MaxPayload = 11'd1500;
  localparam logic [10:0] MinPayload = 11'd46;
  localparam logic [111:0] Header = {DEST_MAC, SRC_MAC, ETHERTYPE};

  typedef enum logic [2:0] {
    StIdle, StPreamble, StHeader, StPayload, StPad, StFcs, StIfg
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q;
  logic            strobe;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [10:0]     count_q, count_d;
  logic [10:0]     byte_cnt_q, byte_cnt_d;
  logic [1:0]      dibit_q, dibit_d;
  logic [1:0]      txd_q, txd_d;
  logic            txen_q, txen_d;
  logic            drop_q, drop_d;
  logic [31:0]     crc_q, crc_d, fcs;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [7:0]      rd_data_q, cur_byte;
  logic [6:0]      hdr_idx;
  logic [4:0]      fcs_idx;
  logic            fifo_full, wr_en, pad_last;

  // Reflected CRC-32 (poly 0xEDB88320), one byte LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  assign strobe    = (div_q == DivW'(CLK_DIV - 1));
  assign fifo_full = ((wr_ptr_q - rd_ptr_q) == PtrW'(FIFO_DEPTH));
  assign busy_out  = (state_q != StIdle);
  assign wr_en     = valid_in && !busy_out && !fifo_full && (count_q != MaxPayload);
  assign fcs       = ~crc_q;
  assign hdr_idx   = 7'd104 - {byte_cnt_q[3:0], 3'b000};
  assign fcs_idx   = {byte_cnt_q[1:0], 3'b000};
  assign pad_last  = (({1'b0, byte_cnt_q} + {1'b0, count_q}) == 12'd45);
  assign drop_out  = drop_q;
  assign eth_txen  = txen_q;
  assign eth_txd   = txd_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    dibit_d    = dibit_q;
    crc_d      = crc_q;
    txen_d     = txen_q;
    txd_d      = txd_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_d     = valid_in && !wr_en;
    cur_byte   = 8'h00;

    case (state_q)
      StPreamble: cur_byte = (byte_cnt_q == 11'd7) ? 8'hD5 : 8'h55;
      StHeader:   cur_byte = Header[hdr_idx +: 8];
      StPayload:  cur_byte = rd_data_q;
      StFcs:      cur_byte = fcs[fcs_idx +: 8];
      default:    cur_byte = 8'h00;
    endcase

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      count_d  = count_q + 11'd1;
    end

    if (state_q == StIdle) begin
      byte_cnt_d = '0;
      dibit_d    = '0;
      crc_d      = '1;
      if (send_in) state_d = StPreamble;
    end

    // Outputs only move on strobe cycles, so each dibit holds for CLK_DIV clocks.
    if (strobe) begin
      txen_d = 1'b0;
      txd_d  = 2'b00;
      if (state_q inside {StPreamble, StHeader, StPayload, StPad, StFcs}) begin
        txen_d  = 1'b1;
        txd_d   = cur_byte[{dibit_q, 1'b0} +: 2];
        dibit_d = dibit_q + 2'd1;
        if (dibit_q == 2'd3) begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          if (state_q inside {StHeader, StPayload, StPad}) crc_d = crc_byte(crc_q, cur_byte);
          case (state_q)
            StPreamble: begin
              if (byte_cnt_q == 11'd7) begin
                byte_cnt_d = '0;
                state_d    = StHeader;
              end
            end
            StHeader: begin
              if (byte_cnt_q == 11'd13) begin
                byte_cnt_d = '0;
                state_d    = (count_q == '0) ? StPad : StPayload;
              end
            end
            StPayload: begin
              rd_ptr_d = rd_ptr_q + PtrW'(1);
              if (byte_cnt_q == count_q - 11'd1) begin
                byte_cnt_d = '0;
                state_d    = (count_q < MinPayload) ? StPad : StFcs;
              end
            end
            StPad: begin
              if (pad_last) begin
                byte_cnt_d = '0;
                state_d    = StFcs;
              end
            end
            StFcs: begin
              if (byte_cnt_q == 11'd3) begin
                byte_cnt_d = '0;
                count_d    = '0;
                state_d    = StIfg;
              end
            end
            default: ;
          endcase
        end
      end else if (state_q == StIfg) begin
        // The first IFG strobe only ends the last FCS dibit; leave on the 49th
        // so 48 full idle dibit periods elapse before busy_out drops.
        byte_cnt_d = byte_cnt_q + 11'd1;
        if (byte_cnt_q == 11'd48) state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      div_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
      dibit_q    <= '0;
      crc_q      <= '1;
      txen_q     <= 1'b0;
      txd_q      <= 2'b00;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= strobe ? '0 : div_q + DivW'(1);
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      dibit_q    <= dibit_d;
      crc_q      <= crc_d;
      txen_q     <= txen_d;
      txd_q      <= txd_d;
      drop_q     <= drop_d;
    end
  end

  // Reading at the next-state pointer keeps rd_data_q aligned with rd_ptr_q.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr_q[AddrW-1:0]] <= data_in;
    rd_data_q <= mem[rd_ptr_d[AddrW-1:0]];
  end

endmodule

// File: tb/tb_rmii_eth_tx.sv
// Self-checking bench for rmii_eth_tx: directed frames, drop cases, back-to-back
// frames and mid-frame reset, with frames decoded from the RMII pins.
module tb_rmii_eth_tx;

  localparam int unsigned ClkDiv = 2;
  localparam logic [47:0] DestMac = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SrcMac = 48'h02_00_00_00_00_01;
  localparam logic [15:0] EtherType = 16'h0800;

  logic       clk_in = 1'b0;
  logic       rst_in, valid_in, send_in;
  logic [7:0] data_in;
  logic       busy_out, drop_out, eth_txen;
  logic [1:0] eth_txd;

  int checks = 0;
  int errors = 0;

  rmii_eth_tx #(
    .DEST_MAC  (DestMac),
    .SRC_MAC   (SrcMac),
    .ETHERTYPE (EtherType),
    .FIFO_DEPTH(2048),
    .CLK_DIV   (ClkDiv)
  ) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .data_in (data_in),
    .valid_in(valid_in),
    .send_in (send_in),
    .busy_out(busy_out),
    .drop_out(drop_out),
    .eth_txen(eth_txen),
    .eth_txd (eth_txd)
  );

  always #5 clk_in = ~clk_in;

  // Pin monitor, sampled on the falling edge.
  logic [1:0] hi_q[$];
  logic [7:0] got_frame[$];
  logic [7:0] exp_pay[$];
  logic [31:0] exp_fcs;
  int idle_txd_err = 0;
  int post_cnt = 0;
  int gap_cnt = 0;
  int last_gap = 0;
  int drop_cnt = 0;
  int d0, t, zeros;

  always @(negedge clk_in) begin
    if (drop_out) drop_cnt <= drop_cnt + 1;
    if (eth_txen) begin
      hi_q.push_back(eth_txd);
      if (gap_cnt > 0) last_gap <= gap_cnt;
      gap_cnt  <= 0;
      post_cnt <= 0;
    end else begin
      gap_cnt <= gap_cnt + 1;
      if (busy_out) post_cnt <= post_cnt + 1;
      if (eth_txd != 2'b00) idle_txd_err <= idle_txd_err + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [1:0] sample(input int i);
    return (i < hi_q.size()) ? hi_q[i] : 2'b00;
  endfunction

  function automatic logic [7:0] got_byte(input int i);
    return (i < got_frame.size()) ? got_frame[i] : 8'h00;
  endfunction

  // Called just after a falling edge; leaves just after a falling edge.
  task automatic write_seq(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      data_in  = base + 8'(i);
      valid_in = 1'b1;
      @(negedge clk_in);
    end
    valid_in = 1'b0;
  endtask

  // Sends the buffered bytes, waits for busy_out to fall and compares the
  // decoded wire frame with a frame built from exp_pay.
  task automatic check_frame(input string tag);
    logic [7:0]  exp_q[$];
    logic [31:0] crc;
    logic [47:0] mac;
    logic [15:0] et;
    int lat, tm, bad, unstable;
    hi_q.delete();
    got_frame.delete();
    send_in = 1'b1;
    @(negedge clk_in);
    send_in = 1'b0;
    lat = 1;
    while (!eth_txen && lat < 20) begin
      @(negedge clk_in);
      lat++;
    end
    check({tag, " latency"}, int'(lat >= 1 && lat <= ClkDiv + 1), 1);
    tm = 0;
    while (busy_out && tm < 20000) begin
      @(negedge clk_in);
      tm++;
    end
    check({tag, " busy_done"}, int'(busy_out), 0);
    #1;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    mac = DestMac;
    for (int i = 0; i < 6; i++) exp_q.push_back(mac[47-8*i -: 8]);
    mac = SrcMac;
    for (int i = 0; i < 6; i++) exp_q.push_back(mac[47-8*i -: 8]);
    et = EtherType;
    exp_q.push_back(et[15:8]);
    exp_q.push_back(et[7:0]);
    foreach (exp_pay[i]) exp_q.push_back(exp_pay[i]);
    while (exp_q.size() < 8 + 14 + 46) exp_q.push_back(8'h00);
    crc = '1;
    for (int i = 8; i < exp_q.size(); i++) crc = crc_upd(crc, exp_q[i]);
    exp_fcs = ~crc;
    exp_q.push_back(exp_fcs[7:0]);
    exp_q.push_back(exp_fcs[15:8]);
    exp_q.push_back(exp_fcs[23:16]);
    exp_q.push_back(exp_fcs[31:24]);

    unstable = 0;
    for (int k = 0; k < hi_q.size() / 2; k++) if (hi_q[2*k] !== hi_q[2*k+1]) unstable++;
    for (int i = 0; i < hi_q.size() / 8; i++)
      got_frame.push_back({hi_q[8*i+6], hi_q[8*i+4], hi_q[8*i+2], hi_q[8*i]});
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_frame.size() || got_frame[i] !== exp_q[i]) bad++;

    check({tag, " txen_cycles"}, hi_q.size(), exp_q.size() * 8);
    check({tag, " byte_errs"}, bad, 0);
    check({tag, " dibit_unstable"}, unstable, 0);
    check({tag, " ifg_cycles"}, post_cnt, 96);
  endtask

  task automatic inject_during_busy();
    int w;
    w = 0;
    while (!busy_out && w < 50) begin
      @(negedge clk_in);
      w++;
    end
    repeat (30) @(negedge clk_in);
    data_in  = 8'hEE;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    check("busy_drop pulse", int'(drop_out), 1);
    @(negedge clk_in);
    check("busy_drop single", int'(drop_out), 0);
    send_in = 1'b1;
    @(negedge clk_in);
    send_in = 1'b0;
  endtask

  initial begin
    rst_in   = 1'b1;
    valid_in = 1'b0;
    send_in  = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge clk_in);
    check("reset busy", int'(busy_out), 0);
    check("reset drop", int'(drop_out), 0);
    check("reset txen", int'(eth_txen), 0);
    check("reset txd", int'(eth_txd), 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Ten-byte payload, padded to the minimum frame.
    exp_pay.delete();
    for (int i = 1; i <= 10; i++) exp_pay.push_back(8'(i));
    write_seq(10, 8'h01);
    check_frame("short");
    check("short dibits", hi_q.size() / 2, 288);
    check("short txen_576", hi_q.size(), 576);
    check("short first_byte_dibits",
          int'({sample(6), sample(4), sample(2), sample(0)}), int'(8'b01_01_01_01));
    check("short sfd_dibits",
          int'({sample(62), sample(60), sample(58), sample(56)}), int'(8'b11_01_01_01));
    zeros = 0;
    for (int i = 32; i < 68; i++) if (got_byte(i) == 8'h00) zeros++;
    check("short pad_zeros", zeros, 36);
    check("short fcs", int'({got_byte(71), got_byte(70), got_byte(69), got_byte(68)}),
          int'(exp_fcs));

    // Byte and send_in while busy are both ignored.
    exp_pay.delete();
    for (int i = 0; i < 4; i++) exp_pay.push_back(8'h11 + 8'(i));
    write_seq(4, 8'h11);
    fork
      check_frame("busy_frame");
      inject_during_busy();
    join
    repeat (3) @(negedge clk_in);
    check("second_send ignored", int'(busy_out), 0);
    exp_pay.delete();
    exp_pay.push_back(8'h21);
    exp_pay.push_back(8'h22);
    write_seq(2, 8'h21);
    check_frame("after_drop");

    // Back-to-back: empty frame sent as soon as busy_out falls.
    exp_pay.delete();
    check_frame("empty");
    check("b2b gap_ge_96", int'(last_gap >= 96), 1);

    // Maximum payload, then one byte too many.
    d0 = drop_cnt;
    exp_pay.delete();
    for (int i = 0; i < 1500; i++) exp_pay.push_back(8'(i));
    write_seq(1500, 8'h00);
    @(negedge clk_in);
    #1;
    check("max no_drop", drop_cnt - d0, 0);
    data_in  = 8'hAB;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    check("max overflow_drop", int'(drop_out), 1);
    check_frame("max");
    check("max wire_bytes", got_frame.size(), 1526);

    // Reset during payload aborts the frame and discards buffered bytes.
    write_seq(20, 8'h40);
    hi_q.delete();
    send_in = 1'b1;
    @(negedge clk_in);
    send_in = 1'b0;
    t = 0;
    while (hi_q.size() < 216 && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    check("abort reached_payload", int'(hi_q.size() >= 216), 1);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("abort txen", int'(eth_txen), 0);
    check("abort busy", int'(busy_out), 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    exp_pay.delete();
    for (int i = 0; i < 46; i++) exp_pay.push_back(8'h80 + 8'(i));
    write_seq(46, 8'h80);
    check_frame("after_abort");
    check("after_abort wire_bytes", got_frame.size(), 72);

    #1;
    check("txd_zero_when_idle", idle_txd_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rmii_eth_tx.md
RMII_ETH_TX -- requirements
Module: rmii_eth_tx

Interface
REQ-001 Parameter DEST_MAC, default 48'hFFFF_FFFF_FFFF, destination MAC sent first on wire.
REQ-002 Parameter SRC_MAC, default 48'h02_00_00_00_00_01, source MAC.
REQ-003 Parameter ETHERTYPE, default 16'h0800, EtherType field.
REQ-004 Parameter FIFO_DEPTH, default 2048, payload buffer depth in bytes (power of two, >= 1500).
REQ-005 Parameter CLK_DIV, default 2, clk_in cycles per RMII dibit (100 MHz clk_in -> 50 MHz RMII rate).
REQ-006 clk_in  input  1  single clock; one clock, all logic on its rising edge.
REQ-007 rst_in  input  1  reset, synchronous, active-high.
REQ-008 data_in  input  8  payload byte from upstream RTP stage.
REQ-009 valid_in  input  1  data_in is valid this cycle.
REQ-010 send_in  input  1  one-cycle pulse: buffered bytes form a complete frame, start transmission.
REQ-011 busy_out  output  1  high from accepted send_in until inter-frame gap complete.
REQ-012 drop_out  output  1  one-cycle pulse when an input byte is discarded.
REQ-013 eth_txen  output  1  RMII TX_EN.
REQ-014 eth_txd  output  2  RMII TXD[1:0].

Function
REQ-015 Bytes with valid_in=1 and busy_out=0 SHALL be written to the FIFO; payload byte count increments, saturating at 1500.
REQ-016 Byte arriving with busy_out=1, FIFO full, or count already 1500 SHALL be discarded, drop_out pulsed next cycle.
REQ-017 send_in with busy_out=0 SHALL set busy_out next cycle; send_in while busy_out=1 SHALL be ignored; send_in with 0 buffered bytes SHALL still send a fully padded frame.
REQ-018 valid_in and send_in in same idle cycle: byte SHALL be included in the frame.
REQ-019 Dibit strobe: free-running counter modulo CLK_DIV; eth_txen/eth_txd change only on strobe cycles, held stable otherwise.
REQ-020 FSM states IDLE -> PREAMBLE -> HEADER -> PAYLOAD -> PAD -> FCS -> IFG -> IDLE; PAD skipped when payload >= 46 bytes.
REQ-021 First dibit SHALL appear at the first strobe at least 1 cycle after send_in (latency <= CLK_DIV+1 cycles).
REQ-022 PREAMBLE: 7 bytes 0x55 then SFD 0xD5.
REQ-023 HEADER: DEST_MAC, SRC_MAC, ETHERTYPE, most-significant byte first (14 bytes).
REQ-024 PAYLOAD: FIFO bytes in write order; PAD: 0x00 bytes until payload+pad = 46.
REQ-025 Every byte SHALL be sent as 4 dibits, LSB first (bits [1:0], [3:2], [5:4], [7:6]).
REQ-026 CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) over HEADER+PAYLOAD+PAD; FCS = ~CRC, sent low byte first.
REQ-027 eth_txen=1 for exactly all PREAMBLE..FCS dibits; eth_txd=2'b00 whenever eth_txen=0.
REQ-028 IFG: eth_txen=0 for 48 dibit periods (96 bit times) before busy_out falls.
REQ-029 FIFO read pointer advances exactly once per payload byte; after FCS the FIFO SHALL be empty and byte count 0.

Reset
REQ-030 rst_in SHALL force state IDLE, FIFO empty, count 0, CRC reload, strobe counter 0.
REQ-031 Reset values: busy_out=0, drop_out=0, eth_txen=0, eth_txd=2'b00, next cycle.
REQ-032 rst_in mid-frame SHALL abort immediately (eth_txen=0 next cycle), no FCS or IFG emitted, buffered bytes discarded.

Verification
REQ-033 10 bytes 0x01..0x0A then send_in -> 288 dibits (8+14+46+4 bytes), eth_txen high 576 clk_in cycles, 36 zero pad bytes, FCS matches software CRC-32 model.
REQ-034 1500 bytes then send_in -> 1526 bytes on wire, no PAD state, no drop_out; 1501st byte -> drop_out pulse, byte absent.
REQ-035 Byte during busy_out=1 -> drop_out pulse, not in current or next frame; second send_in during frame ignored.
REQ-036 Back-to-back frames -> >= 96 clk_in cycles (48 dibits) eth_txen=0 between them; busy_out low only after gap.
REQ-037 rst_in asserted during PAYLOAD -> eth_txen=0, busy_out=0 next cycle; subsequent 46-byte frame transmits correctly.
REQ-038 Check eth_txd stable across non-strobe cycles and first dibits 01,01,01,01 (0x55) then SFD dibits 01,01,01,11.
